alu_rr_scheduler: RTL and testbench

- Shares one 4-bit ALU datapath between two requesters using round-robin arbitration.
- Each requester presents op_code/operands with a valid/ready handshake. The block accepts one operation, computes it, and returns a tagged result on a single response channel with backpressure.
- Sits between the command sources and the ALU result consumer. Exactly one operation is in flight at any time.

---
 rtl/alu_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares a single N-bit ALU between two requesters. A round-robin pointer
//   picks the winner when both request at once. One operation is in flight at
//   a time: IDLE accepts it, EXEC computes it, and RESP presents the tagged
//   result until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  [1:0]  per-requester request strobe
//   req_ready  [1:0]  per-requester grant (one-hot or zero, IDLE only)
//   req0_op/a/b       requester 0 op_code and operands
//   req1_op/a/b       requester 1 op_code and operands
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_id     requester index that issued the result
//   rsp_data   [2N-1:0] result
//   rsp_err    result invalid (divide by zero / unsupported op)
//   busy       high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2:0]     req0_op,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic [2:0]     req1_op,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_data,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic           ptr;
  logic [1:0]     grant;
  logic           sel;

  logic [2:0]     op_p0;
  logic [N-1:0]   a_p0;
  logic [N-1:0]   b_p0;
  logic           id_p0;

  // Returns {err, data}. Operands are zero-extended to the result width so
  // SUB wraps modulo 2^(2N) and MUL keeps the full product.
  function automatic logic [2*N:0] alu_eval(input logic [2:0]   op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [2*N-1:0] ax;
    logic [2*N-1:0] bx;
    logic [2*N-1:0] res;
    logic           err;
    ax  = {{N{1'b0}}, a};
    bx  = {{N{1'b0}}, b};
    res = '0;
    err = 1'b0;
    case (op)
      3'b000: res = ax + bx;
      3'b001: res = ax - bx;
      3'b010: res = ax * bx;
      3'b011: begin
        if (b == '0) err = 1'b1;
        else         res = ax / bx;
      end
      3'b100: res = ax | bx;
      3'b101: res = ax & bx;
      default: err = 1'b1;
    endcase
    return {err, res};
  endfunction

  // Round-robin pick: the pointer only matters when both requesters contend.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    else                    grant = req_valid;
  end

  // Grant is only offered in IDLE and is forced low while reset is asserted.
  assign req_ready = ((state == IDLE) && reset) ? grant : 2'b00;
  assign sel       = grant[1];

  // ---- stage p0: operand capture on handshake ----
  always_ff @(posedge clk) begin
    if (state == IDLE && req_ready != 2'b00) begin
      op_p0 <= sel ? req1_op : req0_op;
      a_p0  <= sel ? req1_a  : req0_a;
      b_p0  <= sel ? req1_b  : req0_b;
      id_p0 <= sel;
    end
  end

  // ---- control FSM, stage p1: result registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready != 2'b00) begin
            ptr   <= ~sel;
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          {rsp_err, rsp_data} <= alu_eval(op_p0, a_p0, b_p0);
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed, table-driven bench for alu_rr_scheduler. Each table row is one
//   clock cycle of stimulus plus the outputs expected in that cycle; a few
//   hand-written sequences cover backpressure, asynchronous reset in flight
//   and pointer fairness.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2:0]     req0_op;
  logic [N-1:0]   req0_a;
  logic [N-1:0]   req0_b;
  logic [2:0]     req1_op;
  logic [N-1:0]   req1_a;
  logic [N-1:0]   req1_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*N-1:0] rsp_data;
  logic           rsp_err;
  logic           busy;

  int n_vec;
  int n_err;

  alu_rr_scheduler #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] rv;
    logic [2:0] op0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] op1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       rr_in;
    logic [1:0] e_rr;
    logic       e_vld;
    logic       e_busy;
    logic       e_id;
    logic [7:0] e_data;
    logic       e_err;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(input logic rst_n, input logic [1:0] rv,
                              input logic [2:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                              input logic [2:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                              input logic [1:0] e_rr, input logic e_vld, input logic e_busy,
                              input logic e_id, input logic [7:0] e_data, input logic e_err);
    vec_t v;
    v.rst_n = rst_n; v.rv = rv;
    v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr_in = 1'b1;
    v.e_rr = e_rr; v.e_vld = e_vld; v.e_busy = e_busy;
    v.e_id = e_id; v.e_data = e_data; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_rr, input logic e_vld,
                           input logic e_busy, input logic e_id, input logic [7:0] e_data,
                           input logic e_err);
    chk({tag, ".req_ready"}, int'(req_ready), int'(e_rr));
    chk({tag, ".rsp_valid"}, int'(rsp_valid), int'(e_vld));
    chk({tag, ".busy"},      int'(busy),      int'(e_busy));
    chk({tag, ".rsp_id"},    int'(rsp_id),    int'(e_id));
    chk({tag, ".rsp_data"},  int'(rsp_data),  int'(e_data));
    chk({tag, ".rsp_err"},   int'(rsp_err),   int'(e_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b1;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;

    //            rst  rv     op0    a0     b0     op1    a1     b1     rr     vld  bsy  id   data   err
    tbl[0]  = mk(1'b1, 2'b01, 3'd0, 4'd9,  4'd8,  3'd0, 4'd0,  4'd0,  2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b1, 2'b00, 3'd0, 4'd9,  4'd8,  3'd0, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tbl[2]  = mk(1'b1, 2'b00, 3'd0, 4'd9,  4'd8,  3'd0, 4'd0,  4'd0,  2'b00, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
    tbl[3]  = mk(1'b1, 2'b00, 3'd0, 4'd9,  4'd8,  3'd0, 4'd0,  4'd0,  2'b00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
    tbl[4]  = mk(1'b0, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[5]  = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[6]  = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tbl[7]  = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b1, 1'b1, 1'b0, 8'hE1, 1'b0);
    tbl[8]  = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b10, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);
    tbl[9]  = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b0);
    tbl[10] = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0);
    tbl[11] = mk(1'b1, 2'b11, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b01, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);
    tbl[12] = mk(1'b1, 2'b00, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0);
    tbl[13] = mk(1'b1, 2'b00, 3'd2, 4'd15, 4'd15, 3'd1, 4'd3,  4'd5,  2'b00, 1'b1, 1'b1, 1'b0, 8'hE1, 1'b0);
    tbl[14] = mk(1'b1, 2'b10, 3'd0, 4'd0,  4'd0,  3'd3, 4'd7,  4'd0,  2'b10, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);
    tbl[15] = mk(1'b1, 2'b00, 3'd0, 4'd0,  4'd0,  3'd3, 4'd7,  4'd0,  2'b00, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b0);
    tbl[16] = mk(1'b1, 2'b00, 3'd0, 4'd0,  4'd0,  3'd3, 4'd7,  4'd0,  2'b00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
    tbl[17] = mk(1'b1, 2'b10, 3'd0, 4'd0,  4'd0,  3'd6, 4'd5,  4'd3,  2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    tbl[18] = mk(1'b1, 2'b00, 3'd0, 4'd0,  4'd0,  3'd6, 4'd5,  4'd3,  2'b00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    tbl[19] = mk(1'b1, 2'b00, 3'd0, 4'd0,  4'd0,  3'd6, 4'd5,  4'd3,  2'b00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
    tbl[20] = mk(1'b1, 2'b10, 3'd0, 4'd0,  4'd0,  3'd3, 4'd13, 4'd4,  2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    tbl[21] = mk(1'b1, 2'b00, 3'd0, 4'd0,  4'd0,  3'd3, 4'd13, 4'd4,  2'b00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    tbl[22] = mk(1'b1, 2'b00, 3'd0, 4'd0,  4'd0,  3'd3, 4'd13, 4'd4,  2'b00, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0);
    tbl[23] = mk(1'b1, 2'b01, 3'd4, 4'hA,  4'h5,  3'd0, 4'd0,  4'd0,  2'b01, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
    tbl[24] = mk(1'b1, 2'b00, 3'd4, 4'hA,  4'h5,  3'd0, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0);
    tbl[25] = mk(1'b1, 2'b00, 3'd4, 4'hA,  4'h5,  3'd0, 4'd0,  4'd0,  2'b00, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0);
    tbl[26] = mk(1'b1, 2'b01, 3'd5, 4'hC,  4'h6,  3'd0, 4'd0,  4'd0,  2'b01, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
    tbl[27] = mk(1'b1, 2'b00, 3'd5, 4'hC,  4'h6,  3'd0, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b0);
    tbl[28] = mk(1'b1, 2'b00, 3'd5, 4'hC,  4'h6,  3'd0, 4'd0,  4'd0,  2'b00, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0);
    tbl[29] = mk(1'b1, 2'b00, 3'd5, 4'hC,  4'h6,  3'd0, 4'd0,  4'd0,  2'b00, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0);

    // Reset state, then release between edges.
    req_valid = 2'b01;
    tick();
    tick();
    check_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    req_valid = 2'b00;
    tick();

    for (int i = 0; i < 30; i++) begin
      reset     = tbl[i].rst_n;
      req_valid = tbl[i].rv;
      req0_op   = tbl[i].op0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
      req1_op   = tbl[i].op1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
      rsp_ready = tbl[i].rr_in;
      #2;
      check_all($sformatf("vec%0d", i), tbl[i].e_rr, tbl[i].e_vld, tbl[i].e_busy,
                tbl[i].e_id, tbl[i].e_data, tbl[i].e_err);
      tick();
    end

    // Response backpressure: result held while the consumer stalls.
    rsp_ready = 1'b0;
    req_valid = 2'b01; req0_op = 3'd0; req0_a = 4'd15; req0_b = 4'd15;
    #2; chk("bp.accept", int'(req_ready), 2'b01);
    tick();
    #2; check_all("bp.exec", 2'b00, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      #2; check_all($sformatf("bp.hold%0d", k), 2'b00, 1'b1, 1'b1, 1'b0, 8'h1E, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #2; check_all("bp.release", 2'b00, 1'b1, 1'b1, 1'b0, 8'h1E, 1'b0);
    tick();
    #2; check_all("bp.idle", 2'b01, 1'b0, 1'b0, 1'b0, 8'h1E, 1'b0);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #2; chk("bp.done", int'(busy), 0);
    tick();

    // Reset asserted during EXEC: outputs clear without a clock edge.
    req_valid = 2'b01; req0_op = 3'd0; req0_a = 4'd1; req0_b = 4'd2;
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    #1;
    check_all("rst_exec", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("rst_exec.drop%0d.vld", k), int'(rsp_valid), 0);
      chk($sformatf("rst_exec.drop%0d.data", k), int'(rsp_data), 0);
      tick();
    end

    // Reset asserted during RESP; the pointer returns to requester 0.
    rsp_ready = 1'b0;
    req_valid = 2'b01; req0_op = 3'd2; req0_a = 4'd3; req0_b = 4'd3;
    tick();
    req_valid = 2'b00;
    tick();
    #2; check_all("rst_resp.pre", 2'b00, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
    reset = 1'b0;
    #1;
    check_all("rst_resp", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b1;
    req_valid = 2'b11;
    #2; chk("rst_resp.ptr", int'(req_ready), 2'b01);
    req_valid = 2'b00;
    tick();
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("rst_resp.drop%0d.vld", k), int'(rsp_valid), 0);
      tick();
    end

    // Fairness: a lone req1 grant hands priority back to req0.
    rsp_ready = 1'b1;
    req_valid = 2'b10; req1_op = 3'd0; req1_a = 4'd1; req1_b = 4'd1;
    req0_op = 3'd4; req0_a = 4'hA; req0_b = 4'h5;
    #2; chk("fair.r1", int'(req_ready), 2'b10);
    tick();
    req_valid = 2'b11;
    #2; chk("fair.exec", int'(req_ready), 2'b00);
    tick();
    #2; check_all("fair.rsp1", 2'b00, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
    tick();
    #2; chk("fair.r0", int'(req_ready), 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    #2; check_all("fair.rsp0", 2'b00, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
